// File: rtl/uart_rx.sv
// UART receiver: 8 data bits LSB first, one stop bit, mid-bit sampling, one-byte valid/ready buffer.
// Optional even parity bit enabled by defining UART_RX_PARITY_EN.
module uart_rx #(
  parameter int unsigned CLK_FREQ     = 100_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned CLKS_PER_BIT = CLK_FREQ / BAUD_RATE
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       rx,
  output logic [7:0] data_out,
  output logic       rx_valid,
  input  logic       rx_ready,
  output logic       busy,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun
);

  localparam int unsigned CNT_W  = 16;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned DATA_W = 8;

  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    LINE_WAIT  = 3'd0,
    IDLE       = 3'd1,
    START_BIT  = 3'd2,
    DATA_BITS  = 3'd3,
    PARITY_BIT = 3'd4,
    STOP_BIT   = 3'd5
  } state_t;

  state_t              state, state_d;
  logic [1:0]          sync_q;
  logic                rxs;
  logic [CNT_W-1:0]    clk_count, cnt_d;
  logic [IDX_W-1:0]    bit_index, idx_d;
  logic [DATA_W-1:0]   shift, shift_d;
  logic                deliver_pend, deliver_d;
  logic                frame_pend, frame_d;
  logic                perr_pend, perr_d;
  logic                par_bad;
  logic [DATA_W-1:0]   data_d;
  logic                valid_d;
  logic                ovr_d;
  logic                busy_d;

  assign rxs = sync_q[1];

`ifdef UART_RX_PARITY_EN
  logic par_bit, par_d;

  // Even parity: data bits plus parity bit must XOR to zero.
  assign par_bad = ^{shift, par_bit};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      par_bit    <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      par_bit    <= par_d;
      parity_err <= perr_pend;
    end
  end
`else
  assign par_bad    = 1'b0;
  assign parity_err = 1'b0;
`endif

  // Line synchroniser, idle-high reset value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= 2'b11;
    else        sync_q <= {sync_q[0], rx};
  end

  // Next-state and datapath for the frame sampler.
  always_comb begin
    state_d   = state;
    cnt_d     = clk_count;
    idx_d     = bit_index;
    shift_d   = shift;
    deliver_d = 1'b0;
    frame_d   = 1'b0;
    perr_d    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_d     = par_bit;
`endif
    case (state)
      LINE_WAIT: begin
        if (rxs) state_d = IDLE;
      end
      IDLE: begin
        if (!rxs) begin
          state_d = START_BIT;
          cnt_d   = '0;
        end
      end
      START_BIT: begin
        if (clk_count == HALF_LAST) begin
          cnt_d   = '0;
          idx_d   = '0;
          state_d = rxs ? IDLE : DATA_BITS;
        end else begin
          cnt_d = clk_count + CNT_W'(1);
        end
      end
      DATA_BITS: begin
        if (clk_count == BIT_LAST) begin
          cnt_d            = '0;
          shift_d[bit_index] = rxs;
          if (bit_index == IDX_W'(7)) begin
`ifdef UART_RX_PARITY_EN
            state_d = PARITY_BIT;
`else
            state_d = STOP_BIT;
`endif
          end else begin
            idx_d = bit_index + IDX_W'(1);
          end
        end else begin
          cnt_d = clk_count + CNT_W'(1);
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY_BIT: begin
        if (clk_count == BIT_LAST) begin
          cnt_d   = '0;
          par_d   = rxs;
          state_d = STOP_BIT;
        end else begin
          cnt_d = clk_count + CNT_W'(1);
        end
      end
`endif
      STOP_BIT: begin
        if (clk_count == BIT_LAST) begin
          cnt_d = '0;
          if (!rxs) begin
            frame_d = 1'b1;
            state_d = LINE_WAIT;
          end else if (par_bad) begin
            perr_d  = 1'b1;
            state_d = IDLE;
          end else begin
            deliver_d = 1'b1;
            state_d   = IDLE;
          end
        end else begin
          cnt_d = clk_count + CNT_W'(1);
        end
      end
      default: state_d = LINE_WAIT;
    endcase
  end

  // Output buffer: load, drop-with-overrun, or clear on accept.
  always_comb begin
    data_d  = data_out;
    valid_d = rx_valid;
    ovr_d   = 1'b0;
    busy_d  = (state_d != IDLE);
    if (deliver_pend) begin
      if (!rx_valid || rx_ready) begin
        data_d  = shift;
        valid_d = 1'b1;
      end else begin
        ovr_d = 1'b1;
      end
    end else if (rx_valid && rx_ready) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= LINE_WAIT;
      clk_count    <= '0;
      bit_index    <= '0;
      shift        <= '0;
      deliver_pend <= 1'b0;
      frame_pend   <= 1'b0;
      perr_pend    <= 1'b0;
      data_out     <= '0;
      rx_valid     <= 1'b0;
      busy         <= 1'b1;
      frame_err    <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_d;
      clk_count    <= cnt_d;
      bit_index    <= idx_d;
      shift        <= shift_d;
      deliver_pend <= deliver_d;
      frame_pend   <= frame_d;
      perr_pend    <= perr_d;
      data_out     <= data_d;
      rx_valid     <= valid_d;
      busy         <= busy_d;
      frame_err    <= frame_pend;
      overrun      <= ovr_d;
    end
  end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx at 10 clocks per bit.
module tb_uart_rx;

  localparam int CPB = 10;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic [7:0] data_out;
  logic       rx_valid, busy, frame_err, parity_err, overrun;

  int total = 0;
  int bad = 0;
  int n_valid = 0, n_frame = 0, n_par = 0, n_ovr = 0;
  int v0, f0, p0, o0;
  logic [7:0] exp_q[$];

  uart_rx #(
    .CLK_FREQ(1_000_000),
    .BAUD_RATE(100_000),
    .CLKS_PER_BIT(CPB)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .rx(rx),
    .data_out(data_out),
    .rx_valid(rx_valid),
    .rx_ready(rx_ready),
    .busy(busy),
    .frame_err(frame_err),
    .parity_err(parity_err),
    .overrun(overrun)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", name, got, want);
    end
  endtask

  // Stimulus changes just after the rising edge so the monitor sees stable values.
  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send_bits(input logic [10:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      rx = bits[i];
      cyc(CPB);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic stop);
`ifdef UART_RX_PARITY_EN
    send_bits({stop, ^d, d, 1'b0}, 11);
`else
    send_bits(11'({stop, d, 1'b0}), 10);
`endif
  endtask

  task automatic snap();
    v0 = n_valid; f0 = n_frame; p0 = n_par; o0 = n_ovr;
  endtask

  // Pops the expected byte on each accept and checks buffer stability while held.
  task automatic monitor();
    logic       hold_prev;
    logic [7:0] prev_data;
    logic [7:0] e;
    hold_prev = 1'b0;
    prev_data = '0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        hold_prev = 1'b0;
      end else begin
        if (rx_valid)   n_valid++;
        if (frame_err)  n_frame++;
        if (parity_err) n_par++;
        if (overrun)    n_ovr++;
        if (hold_prev && rx_valid) check("data_stable", 32'(data_out), 32'(prev_data));
        if (rx_valid && rx_ready) begin
          if (exp_q.size() == 0) begin
            check("unexpected_byte", 32'(data_out), 32'hFFFF_FFFF);
          end else begin
            e = exp_q.pop_front();
            check("rx_byte", 32'(data_out), 32'(e));
          end
        end
        hold_prev = rx_valid && !rx_ready;
        prev_data = data_out;
      end
    end
  endtask

  initial begin
    fork
      monitor();
    join_none

    // Reset values
    cyc(3);
    check("rst_data", 32'(data_out), 32'h00);
    check("rst_valid", 32'(rx_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd1);
    check("rst_errs", 32'({frame_err, parity_err, overrun}), 32'd0);
    rst_n = 1'b1;
    cyc(5);
    check("idle_after_rst", 32'(busy), 32'd0);

    // Single byte, ready high
    snap();
    exp_q.push_back(8'hA5);
    send_frame(8'hA5, 1'b1);
    cyc(5);
    check("a5_valid_width", 32'(n_valid - v0), 32'd1);
    check("a5_errs", 32'((n_frame - f0) + (n_par - p0) + (n_ovr - o0)), 32'd0);
    check("a5_busy", 32'(busy), 32'd0);

    // Back-to-back with consumer stalled: second byte overruns
    snap();
    rx_ready = 1'b0;
    exp_q.push_back(8'h3C);
    send_frame(8'h3C, 1'b1);
    send_frame(8'hC3, 1'b1);
    cyc(5);
    check("ovr_valid_held", 32'(rx_valid), 32'd1);
    check("ovr_data_kept", 32'(data_out), 32'h3C);
    check("ovr_pulse", 32'(n_ovr - o0), 32'd1);
    rx_ready = 1'b1;
    cyc(1);
    check("accept_falls", 32'(rx_valid), 32'd0);

    // Framing error with line held low, then recovery
    snap();
    send_frame(8'h55, 1'b0);
    rx = 1'b0;
    cyc(30);
    check("fe_pulse", 32'(n_frame - f0), 32'd1);
    check("fe_no_valid", 32'(n_valid - v0), 32'd0);
    check("fe_line_wait", 32'(busy), 32'd1);
    rx = 1'b1;
    cyc(10);
    check("fe_recover_idle", 32'(busy), 32'd0);
    exp_q.push_back(8'h12);
    send_frame(8'h12, 1'b1);
    cyc(5);

    // Short glitch on idle line
    snap();
    rx = 1'b0;
    cyc(3);
    rx = 1'b1;
    check("glitch_busy", 32'(busy), 32'd1);
    cyc(8);
    check("glitch_idle", 32'(busy), 32'd0);
    check("glitch_quiet", 32'((n_valid - v0) + (n_frame - f0) + (n_par - p0) + (n_ovr - o0)), 32'd0);

    // Reset in the middle of data bit 4 of 8'hFF
    rx = 1'b0;
    cyc(CPB);
    rx = 1'b1;
    cyc(4 * CPB + 5);
    rst_n = 1'b0;
    #1;
    check("mid_rst_data", 32'(data_out), 32'h00);
    check("mid_rst_valid", 32'(rx_valid), 32'd0);
    check("mid_rst_busy", 32'(busy), 32'd1);
    check("mid_rst_errs", 32'({frame_err, parity_err, overrun}), 32'd0);
    cyc(CPB * 6);
    rst_n = 1'b1;
    cyc(5);
    exp_q.push_back(8'h81);
    send_frame(8'h81, 1'b1);
    cyc(5);

`ifdef UART_RX_PARITY_EN
    // Good and bad parity
    snap();
    exp_q.push_back(8'h07);
    send_bits({1'b1, 1'b1, 8'h07, 1'b0}, 11);
    cyc(5);
    check("par_ok_valid", 32'(n_valid - v0), 32'd1);
    check("par_ok_noerr", 32'(n_par - p0), 32'd0);
    snap();
    send_bits({1'b1, 1'b0, 8'h07, 1'b0}, 11);
    cyc(5);
    check("par_err_pulse", 32'(n_par - p0), 32'd1);
    check("par_err_no_valid", 32'(n_valid - v0), 32'd0);
`else
    check("parity_tied", 32'(n_par), 32'd0);
`endif

    cyc(5);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver with 8 data bits, LSB first, and one stop bit. It is the receive-side counterpart of the team's `uart_tx`, uses the same baud parameterisation, and sits between the board RX pin and the game-logic command decoder. It synchronises the line and samples each bit at mid-bit. Each received byte is presented on a valid/ready handshake with one byte of output buffering, and framing, parity and overrun conditions are reported as one-cycle pulses.

## Interface
Parameters:
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate.
- `CLKS_PER_BIT`, default CLK_FREQ / BAUD_RATE (10416): clocks per bit; minimum legal value is 4.

Ports:
- `clk`, in, 1: system clock, rising edge.
- `rst_n`, in, 1: asynchronous, active-low reset.
- `rx`, in, 1: UART line, idle high, asynchronous to `clk`.
- `data_out`, out, 8: received byte, valid while `rx_valid`=1.
- `rx_valid`, out, 1: byte available.
- `rx_ready`, in, 1: consumer accepts the byte on an edge where `rx_valid`=1 and `rx_ready`=1.
- `busy`, out, 1: high in every state except IDLE.
- `frame_err`, out, 1: one-cycle pulse; stop bit sampled low.
- `parity_err`, out, 1: one-cycle pulse; parity mismatch (see Configuration).
- `overrun`, out, 1: one-cycle pulse; a completed byte was dropped because the buffer was full.

## Operation
- `rx` passes through a 2-FF synchroniser, reset value 1'b1. All decisions use the synchronised value `rxs`.
- Internal state: a 16-bit `clk_count`, a 3-bit `bit_index` and an 8-bit shift register.
- Reset values: `data_out`=8'h00, `rx_valid`=0, `busy`=1, `frame_err`=`parity_err`=`overrun`=0, state=LINE_WAIT.
- LINE_WAIT: stay until `rxs`=1, then go to IDLE. This prevents a held-low line after reset or after a break from being read as a start bit.
- IDLE: when `rxs`=0, go to START_BIT with `clk_count`=0.
- START_BIT:
  - count to CLKS_PER_BIT/2 − 1 (integer division), then sample.
  - if `rxs`=1, it is a glitch: return to IDLE with no output.
  - otherwise go to DATA_BITS with `clk_count`=0 and `bit_index`=0.
- DATA_BITS:
  - at `clk_count`=CLKS_PER_BIT−1, sample `rxs` into bit[`bit_index`] and reset the counter.
  - after `bit_index`=7, go to PARITY_BIT if it is compiled in, otherwise to STOP_BIT.
- STOP_BIT: at `clk_count`=CLKS_PER_BIT−1, sample.
  - 1 with no parity error: deliver the byte, go to IDLE.
  - 0: pulse `frame_err`, discard the byte, go to LINE_WAIT.
  - 1 with a parity error: pulse `parity_err`, discard the byte, go to IDLE.
- Delivery, evaluated on the edge after the stop sample:
  - if `rx_valid`=0, or `rx_valid`=1 and `rx_ready`=1 on that same edge: load `data_out` and set `rx_valid`=1. A simultaneous accept and load leaves `rx_valid` at 1 and raises no overrun.
  - else: drop the new byte, keep `data_out` unchanged, pulse `overrun`.
- Handshake:
  - `rx_valid` falls on the edge after acceptance unless a new byte is loaded on that same edge.
  - `data_out` is stable while `rx_valid`=1 and not accepted.
  - `rx_ready` is ignored while `rx_valid`=0.
- Any undefined state encoding goes to LINE_WAIT.

## Timing
- Synchroniser latency is 2 clocks from the `rx` pin to `rxs`.
- Sample points, measured from the cycle `rxs` first reads 0 in IDLE:
  - start bit at +CLKS_PER_BIT/2;
  - data bit k at +CLKS_PER_BIT/2 + (k+1)·CLKS_PER_BIT;
  - stop bit at +CLKS_PER_BIT/2 + 9·CLKS_PER_BIT, or 10·CLKS_PER_BIT when parity is compiled in.
- `rx_valid` rises 1 clock after the stop sample.
- The error pulses are exactly 1 clock wide and are aligned with that delivery cycle.
- The receiver is back in IDLE half a bit before the nominal end of the stop bit, so back-to-back frames are received with no gap.
- Reset asserted mid-frame: all outputs return to their reset values immediately, the partial byte is lost, and a buffered undelivered byte is lost.

## Configuration
- Macro `UART_RX_PARITY_EN`.
- Defined:
  - adds a PARITY_BIT state after DATA_BITS, sampled at CLKS_PER_BIT−1 like a data bit;
  - even parity: the XOR of the 8 data bits and the parity bit must be 0;
  - a mismatch raises `parity_err` as described in Operation;
  - the frame is 11 bits.
- Undefined:
  - there is no PARITY_BIT state and the frame is 10 bits;
  - `parity_err` is tied to 0.

## Test plan
Bench settings: CLK_FREQ=1_000_000, BAUD_RATE=100_000 (CLKS_PER_BIT=10).
- Send 8'hA5 with a valid stop bit and `rx_ready`=1 -> `rx_valid` pulses 1 cycle with `data_out`=8'hA5; no error pulses; `busy` returns to 0.
- Hold `rx_ready`=0 and send 8'h3C then 8'hC3 back-to-back -> `data_out` stays 8'h3C with `rx_valid` held at 1, and `overrun` pulses once at the 8'hC3 stop sample. Then raise `rx_ready` -> `rx_valid` falls on the next edge.
- Send 8'h55 with the stop bit driven 0 and the line held low for 30 clocks -> `frame_err` pulses, `rx_valid` stays 0, and the block stays in LINE_WAIT until the line goes high. A following 8'h12 is received correctly.
- Drive a 3-clock low glitch on an idle line -> no `rx_valid`, no error pulses, back in IDLE within 8 clocks.
- Assert `rst_n`=0 during data bit 4 of 8'hFF -> all outputs take their reset values at once. After release, a full 8'h81 frame is received correctly.
- With `UART_RX_PARITY_EN` defined, send 8'h07 with parity bit 1 -> `data_out`=8'h07. Send 8'h07 with parity bit 0 -> `parity_err` pulses and `rx_valid` stays 0.
